// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: FSM state
// encoding, parity-type codes, legal oversampling ratios and the latched
// per-frame configuration.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Configuration captured at the start edge and held for the whole frame.
  typedef struct packed {
    logic [5:0] prescale;
    logic       par_en;
    logic       par_type;
  } frame_cfg_t;

  // Anything other than 16 or 32 clocks per bit falls back to 8.
  function automatic logic [5:0] norm_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_framer_data_sampling.sv
// Per-bit edge counter and 3-point majority sampler. The counter runs
// 0..P-1 while the framer is inside a frame and sits at 0 in idle, so the
// first bit period starts counting on the cycle after the start edge.
module data_sampling (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  output logic       bit_end,
  output logic       sampled_bit
);

  logic [5:0] edge_cnt;
  logic [5:0] half;
  logic [5:0] last;
  logic [2:0] smp;

  assign half = {1'b0, prescale[5:1]};
  assign last = prescale - 6'd1;

  // Edge counter: wraps at P-1, held at zero whenever no frame is active.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      edge_cnt <= '0;
    end else if (edge_cnt == last) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  // Capture the line at the three points around mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp <= '0;
    end else if (en) begin
      if (edge_cnt == half - 6'd1) smp[0] <= rx_in;
      if (edge_cnt == half)        smp[1] <= rx_in;
      if (edge_cnt == half + 6'd1) smp[2] <= rx_in;
    end
  end

  // All three samples are settled by the last count of the bit.
  assign bit_end     = en && (edge_cnt == last);
  assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: start / data / optional parity / stop sequencing on
// top of the majority sampler. Parity checking is done outside; this block
// presents the word and parity bit, strobes the checker for one cycle and
// folds its verdict into the end-of-frame status pulses.
module uart_rx_framer
  import uart_rx_pkg::*;
#(
  parameter int   WIDTH = 8,
  parameter logic EVEN  = PAR_EVEN,
  parameter logic ODD   = PAR_ODD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  input  logic [5:0]       prescale,
  input  logic             par_en,
  input  logic             par_type,
  input  logic             par_err,
  output logic [WIDTH-1:0] p_data,
  output logic             par_bit,
  output logic             par_chk_en,
  output logic             data_valid,
  output logic             par_err_out,
  output logic             strt_err,
  output logic             stp_err
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  rx_state_e      state;
  frame_cfg_t     cfg_q;
  logic [BCW-1:0] bit_cnt;
  logic           par_err_q;
  logic           chk_phase;
  logic           bit_end;
  logic           sampled_bit;
  logic           ptype_ok;

  // A par_type code matching neither configured code cannot be checked
  // meaningfully, so such a frame is reported as a parity failure.
  assign ptype_ok = (cfg_q.par_type == EVEN) || (cfg_q.par_type == ODD);

  data_sampling u_sampling (
    .clk         (clk),
    .rst         (rst),
    .en          (state != ST_IDLE),
    .rx_in       (rx_in),
    .prescale    (cfg_q.prescale),
    .bit_end     (bit_end),
    .sampled_bit (sampled_bit)
  );

  // Frame FSM with registered data and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cfg_q       <= '{prescale: PRESCALE_8, par_en: 1'b0, par_type: 1'b0};
      bit_cnt     <= '0;
      par_err_q   <= 1'b0;
      chk_phase   <= 1'b0;
      p_data      <= '0;
      par_bit     <= 1'b0;
      par_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      par_err_out <= 1'b0;
      strt_err    <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      par_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      par_err_out <= 1'b0;
      strt_err    <= 1'b0;
      stp_err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_in) begin
            state     <= ST_START;
            cfg_q     <= '{prescale: norm_prescale(prescale),
                           par_en:   par_en,
                           par_type: par_type};
            bit_cnt   <= '0;
            par_err_q <= 1'b0;
            chk_phase <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            if (!sampled_bit) begin
              state <= ST_DATA;
            end else begin
              strt_err <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            p_data  <= {sampled_bit, p_data[WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= cfg_q.par_en ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          // Second phase: the checker has seen par_chk_en for one cycle.
          if (chk_phase) begin
            par_err_q <= par_err | !ptype_ok;
            chk_phase <= 1'b0;
            state     <= ST_STOP;
          end else if (bit_end) begin
            par_bit    <= sampled_bit;
            par_chk_en <= 1'b1;
            chk_phase  <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state       <= ST_IDLE;
            stp_err     <= !sampled_bit;
            par_err_out <= par_err_q;
            data_valid  <= sampled_bit & !par_err_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame.
REQ-002 SHALL have parameter EVEN, default 0, par_type code for even parity.
REQ-003 SHALL have parameter ODD, default 1, par_type code for odd parity.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_in  in  1  serial line; idle high; LSB first.
REQ-007 SHALL have port prescale  in  6  clk cycles per bit (8, 16 or 32).
REQ-008 SHALL have port par_en  in  1  frame carries a parity bit.
REQ-009 SHALL have port par_type  in  1  EVEN/ODD.
REQ-010 SHALL have port par_err  in  1  error result returned by the downstream parity checker.
REQ-011 SHALL have port p_data  out  WIDTH  assembled data word.
REQ-012 SHALL have port par_bit  out  1  received parity bit.
REQ-013 SHALL have port par_chk_en  out  1  enable strobe to the parity checker.
REQ-014 SHALL have port data_valid  out  1  one-cycle pulse, frame good.
REQ-015 SHALL have port par_err_out  out  1  one-cycle pulse, parity failure.
REQ-016 SHALL have port strt_err  out  1  one-cycle pulse, false start.
REQ-017 SHALL have port stp_err  out  1  one-cycle pulse, bad stop bit.

Function
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL leave IDLE for START on rx_in==0 sampled in IDLE; edge counter cleared to 0 on that cycle.
REQ-020 SHALL latch prescale and par_en/par_type on leaving IDLE; values other than 8, 16, 32 SHALL be treated as 8.
REQ-021 SHALL count edge_cnt 0..P-1 per bit period, wrapping to 0, where P is the latched prescale.
REQ-022 SHALL sample rx_in at edge_cnt = P/2-1, P/2 and P/2+1; bit value = majority of the three.
REQ-023 SHALL evaluate the bit at edge_cnt == P-1 (bit end).
REQ-024 START SHALL go to DATA if the start bit is 0; otherwise it SHALL pulse strt_err and return to IDLE.
REQ-025 DATA SHALL shift bits into p_data LSB-first; after WIDTH bits it SHALL go to PARITY if par_en, else to STOP.
REQ-026 PARITY SHALL load par_bit at bit end, then hold par_chk_en high for exactly the next cycle.
REQ-027 The block SHALL register par_err during that cycle and go to STOP.
REQ-028 STOP bit 0 SHALL pulse stp_err.
REQ-029 STOP bit 1 with no registered parity error SHALL pulse data_valid.
REQ-030 A registered parity error SHALL pulse par_err_out instead of data_valid; a frame with a bad stop SHALL suppress data_valid.
REQ-031 All pulses SHALL be issued the cycle after STOP bit end, together with the return to IDLE.
REQ-032 A start edge on that same cycle SHALL be recognised (back-to-back frames).
REQ-033 p_data and par_bit SHALL hold their last values until the next frame overwrites them.
REQ-034 Latency SHALL be last-bit end + 1 cycle; a frame is (1+WIDTH+par_en+1)*P cycles long.
REQ-035 par_en/par_type/prescale changes mid-frame SHALL have no effect.

Reset
REQ-036 rst high SHALL force IDLE on the next clk edge, clearing edge/bit counters.
REQ-037 rst SHALL force all outputs (p_data, par_bit, par_chk_en, data_valid, par_err_out, strt_err, stp_err) to 0.
REQ-038 rst mid-frame SHALL abandon the frame with no pulse; rst has priority over every other event.

Structure
REQ-039 State encodings, EVEN/ODD codes and legal prescale constants SHALL live in the shared uart_rx package.
REQ-040 Sampling (edge counter plus 3-sample majority) SHALL be one sub-module, data_sampling.
REQ-041 The parity checker SHALL remain external, wired via par_bit, p_data, par_chk_en and par_err.

Verification
REQ-042 Case: P=8, par_en=0, frame 0x A5 -> data_valid pulse 80 cycles after start edge, p_data=0xA5.
REQ-043 Case: P=16, par_en=1, EVEN, 0x3C with parity 0 -> par_chk_en 1 cycle, data_valid, no errors.
REQ-044 Case: same as REQ-043 with parity bit 1 -> par_err_out pulse, no data_valid.
REQ-045 Case: P=8, start low for 2 cycles only -> strt_err pulse, FSM IDLE, no data_valid.
REQ-046 Case: P=32, stop bit 0 -> stp_err pulse; a single-cycle glitch on a sample point -> majority keeps correct bit.
REQ-047 Case: rst asserted in DATA, then a clean frame 0x5A -> no pulse from the aborted frame; 0x5A received correctly.
